// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file constants, write-port FSM states and write-request type
package rf_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 32;
  typedef enum logic {CLEAR, RUN} rf_state_t;
  typedef struct packed {
    logic valid;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter with combinational one-hot grant
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last;
  // on a tie, grant whichever requester did not win most recently
  always_comb gnt = {req[1] & (~req[0] | ~last), req[0] & (~req[1] | last)};
  // remember the winner; reset points at requester 1 so the first tie goes to requester 0
  always_ff @(posedge clk)
    if (rst) last <= 1'b1;
    else if (|gnt) last <= gnt[1];
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: clears x1..x31 after reset, then round-robins the register-file write port
module regfile_write_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W,
  parameter int NUM_REGS = rf_pkg::NUM_REGS,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] rf_rd,
  output logic              rf_write_enable,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              init_done
);
  rf_state_t state;
  logic [ADDR_W-1:0] clr_cnt;
  logic clr_last, clearing, run;
  logic [1:0] req, gnt;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  // clear sequencer: walk x1..x(NUM_REGS-1) once, then stay in RUN until reset
  always_ff @(posedge clk)
    if (rst) begin
      state <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_cnt <= ADDR_W'(1);
    end else if (state == CLEAR) begin
      state <= clr_last ? RUN : CLEAR;
      clr_cnt <= clr_last ? clr_cnt : clr_cnt + 1'b1;
    end
  // requests reach the arbiter only in RUN and never while reset is asserted
  always_comb begin
    clr_last = clr_cnt == ADDR_W'(NUM_REGS - 1);
    clearing = state == CLEAR && !rst;
    run = state == RUN && !rst;
    req = {req1_valid, req0_valid} & {2{run}};
  end
  rr_arbiter2 u_arb (
    .clk(clk),
    .rst(rst),
    .req(req),
    .gnt(gnt)
  );
  // write-port mux: clear writes, else granted requester; rd==0 is accepted but not written
  always_comb begin
    sel_rd = gnt[1] ? req1_rd : gnt[0] ? req0_rd : '0;
    sel_data = gnt[1] ? req1_data : gnt[0] ? req0_data : '0;
    rf_rd = clearing ? clr_cnt : sel_rd;
    rf_write_data = clearing ? '0 : sel_data;
    rf_write_enable = clearing | (|gnt & (sel_rd != '0));
    req0_ready = gnt[0];
    req1_ready = gnt[1];
    init_done = run;
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed-vector bench with a behavioural register file on the write port
module tb_regfile_write_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst1 = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [4:0] req0_rd = '0, req1_rd = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready, rf_write_enable, init_done;
  logic [4:0] rf_rd;
  logic [31:0] rf_write_data;
  logic o1_req0_ready, o1_req1_ready, o1_we, o1_init_done;
  logic [4:0] o1_rd;
  logic [31:0] o1_data;
  logic [31:0] mem [32];
  int vec = 0;
  int errs = 0;

  regfile_write_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_rd(rf_rd), .rf_write_enable(rf_write_enable), .rf_write_data(rf_write_data),
    .init_done(init_done)
  );

  regfile_write_arbiter #(.CLEAR_ON_RESET(1'b0)) dut_nc (
    .clk(clk), .rst(rst1),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(o1_req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(o1_req1_ready),
    .rf_rd(o1_rd), .rf_write_enable(o1_we), .rf_write_data(o1_data),
    .init_done(o1_init_done)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 32; i++) mem[i] = 32'hdead_beef;
  always @(posedge clk) if (rf_write_enable) mem[rf_rd] <= rf_write_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vec++;
    if ({rf_write_enable, req0_ready, req1_ready, init_done, rf_rd, rf_write_data} !== '0) begin
      errs++;
      $display("FAIL reset_outputs got we=%b r0=%b r1=%b init=%b rd=%0d data=%0h want all 0",
               rf_write_enable, req0_ready, req1_ready, init_done, rf_rd, rf_write_data);
    end
    rst = 1'b0;
    #1;
    for (int i = 1; i < 32; i++) begin
      vec++;
      if (rf_write_enable !== 1'b1 || rf_rd !== 5'(i) || rf_write_data !== 32'h0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0 || init_done !== 1'b0) begin
        errs++;
        $display("FAIL clear_cycle_%0d got we=%b rd=%0d data=%0h r0=%b r1=%b init=%b want we=1 rd=%0d data=0 r=0 init=0",
                 i, rf_write_enable, rf_rd, rf_write_data, req0_ready, req1_ready, init_done, i);
      end
      tick();
    end
    vec++;
    if (init_done !== 1'b1 || rf_write_enable !== 1'b0) begin
      errs++;
      $display("FAIL clear_done got init=%b we=%b want init=1 we=0", init_done, rf_write_enable);
    end
    vec++;
    if (mem[4] !== 32'h0 || mem[31] !== 32'h0 || mem[1] !== 32'h0) begin
      errs++;
      $display("FAIL clear_readback got x1=%0h x4=%0h x31=%0h want 0", mem[1], mem[4], mem[31]);
    end
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_rd = 5'd4; req0_data = 32'd40;
    #1;
    vec++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || rf_rd !== 5'd4 ||
        rf_write_enable !== 1'b1 || rf_write_data !== 32'd40) begin
      errs++;
      $display("FAIL single_grant got r0=%b r1=%b rd=%0d we=%b data=%0d want r0=1 r1=0 rd=4 we=1 data=40",
               req0_ready, req1_ready, rf_rd, rf_write_enable, rf_write_data);
    end
    tick();
    req0_valid = 1'b0;
    #1;
    vec++;
    if (mem[4] !== 32'd40) begin
      errs++;
      $display("FAIL single_readback got x4=%0d want 40", mem[4]);
    end
    vec++;
    if (rf_write_enable !== 1'b0 || req0_ready !== 1'b0 || rf_rd !== 5'd0 || rf_write_data !== 32'd0) begin
      errs++;
      $display("FAIL idle got we=%b r0=%b rd=%0d data=%0h want we=0 r0=0 rd=0 data=0",
               rf_write_enable, req0_ready, rf_rd, rf_write_data);
    end
  endtask

  task automatic test_x0();
    req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'd100;
    #1;
    vec++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0 || rf_write_enable !== 1'b0) begin
      errs++;
      $display("FAIL x0_write got r1=%b r0=%b we=%b want r1=1 r0=0 we=0", req1_ready, req0_ready, rf_write_enable);
    end
    tick();
    req1_valid = 1'b0;
    #1;
    vec++;
    if (mem[0] !== 32'hdead_beef) begin
      errs++;
      $display("FAIL x0_untouched got x0_slot=%0h want deadbeef", mem[0]);
    end
  endtask

  task automatic test_contention();
    logic [1:0] want;
    req0_valid = 1'b1; req0_rd = 5'd10; req0_data = 32'd100;
    req1_valid = 1'b1; req1_rd = 5'd11; req1_data = 32'd200;
    #1;
    for (int k = 0; k < 4; k++) begin
      want = k[0] ? 2'b10 : 2'b01;
      vec++;
      if ({req1_ready, req0_ready} !== want || rf_rd !== (k[0] ? 5'd11 : 5'd10) ||
          rf_write_data !== (k[0] ? 32'd200 : 32'd100) || rf_write_enable !== 1'b1) begin
        errs++;
        $display("FAIL contention_%0d got gnt=%b rd=%0d data=%0d we=%b want gnt=%b",
                 k, {req1_ready, req0_ready}, rf_rd, rf_write_data, rf_write_enable, want);
      end
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    vec++;
    if (mem[10] !== 32'd100 || mem[11] !== 32'd200) begin
      errs++;
      $display("FAIL contention_readback got x10=%0d x11=%0d want 100 200", mem[10], mem[11]);
    end
  endtask

  task automatic test_mid_clear();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    for (int i = 1; i < 10; i++) tick();
    vec++;
    if (rf_rd !== 5'd10 || rf_write_enable !== 1'b1) begin
      errs++;
      $display("FAIL mid_clear_pos got rd=%0d we=%b want rd=10 we=1", rf_rd, rf_write_enable);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'd77;
    #1;
    for (int i = 1; i < 32; i++) begin
      vec++;
      if (rf_rd !== 5'(i) || rf_write_enable !== 1'b1 || req0_ready !== 1'b0 || init_done !== 1'b0) begin
        errs++;
        $display("FAIL restart_cycle_%0d got rd=%0d we=%b r0=%b init=%b want rd=%0d we=1 r0=0 init=0",
                 i, rf_rd, rf_write_enable, req0_ready, init_done, i);
      end
      tick();
    end
    vec++;
    if (init_done !== 1'b1 || req0_ready !== 1'b1 || rf_rd !== 5'd7 || rf_write_data !== 32'd77) begin
      errs++;
      $display("FAIL held_req_first_run got init=%b r0=%b rd=%0d data=%0d want init=1 r0=1 rd=7 data=77",
               init_done, req0_ready, rf_rd, rf_write_data);
    end
    tick();
    req0_valid = 1'b0;
    #1;
    vec++;
    if (mem[7] !== 32'd77) begin
      errs++;
      $display("FAIL held_req_readback got x7=%0d want 77", mem[7]);
    end
  endtask

  task automatic test_no_clear();
    req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'd7;
    #1;
    vec++;
    if (o1_req0_ready !== 1'b0 || o1_we !== 1'b0 || o1_init_done !== 1'b0) begin
      errs++;
      $display("FAIL nc_in_reset got r0=%b we=%b init=%b want 0 0 0", o1_req0_ready, o1_we, o1_init_done);
    end
    tick();
    rst1 = 1'b0;
    #1;
    vec++;
    if (o1_init_done !== 1'b1 || o1_req0_ready !== 1'b1 || o1_req1_ready !== 1'b0 ||
        o1_rd !== 5'd5 || o1_we !== 1'b1 || o1_data !== 32'd7) begin
      errs++;
      $display("FAIL nc_first_grant got init=%b r0=%b r1=%b rd=%0d we=%b data=%0d want init=1 r0=1 r1=0 rd=5 we=1 data=7",
               o1_init_done, o1_req0_ready, o1_req1_ready, o1_rd, o1_we, o1_data);
    end
    tick();
    req0_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_x0();
    test_contention();
    test_mid_clear();
    test_no_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
